aes_rkey_store: RTL and testbench

AES_RKEY_STORE -- requirements
Module: aes_rkey_store

---
 rtl/aes_rkey_store.sv | 112 +++++++++++
 tb/tb_aes_rkey_store.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_rkey_store.sv
// aes_rkey_store: AES round-key storage, loaded by the key expander and read by the round FSM
// Ports: clk, reset (async, active-high); mode/load_start/flush control a schedule load;
// wr_valid/wr_key/wr_ready take keys from the expander; rd_req/rd_round/enc_dec request a key;
// rd_valid/rd_key/rd_err answer one cycle later; load_done pulses after the last key; nr is the round count.
// AES_RKEY_ZEROIZE_EN: flush and reload wipe every entry through a ZERO state before continuing.
module aes_rkey_store #(
  parameter int KEY_W = 128,
  parameter int DEPTH = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             load_start,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [KEY_W-1:0] wr_key,
  output logic             wr_ready,
  input  logic             rd_req,
  input  logic [3:0]       rd_round,
  input  logic             enc_dec,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_err,
  output logic             load_done,
  output logic [3:0]       nr
);
`ifdef AES_RKEY_ZEROIZE_EN
  typedef enum logic [1:0] {IDLE, LOAD, FULL, ZERO} state_t;
  logic [3:0] z_ptr;
  logic       z_load;
`else
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
`endif
  state_t           state;
  logic [1:0]       mode_q;
  logic [3:0]       wr_ptr, last, idx;
  logic [KEY_W-1:0] mem [DEPTH];
  logic             bad_mode, restart, wr_en, rd_ok;
  assign last     = 4'd10 + {1'b0, mode_q, 1'b0};
  assign bad_mode = !flush && load_start && mode == 2'b11;
  assign restart  = !flush && load_start && mode != 2'b11;
  // a load request or flush in the same cycle pre-empts writes and reads
  assign wr_en    = !flush && !load_start && state == LOAD && wr_valid;
  assign rd_ok    = !flush && !load_start && state == FULL && rd_req && rd_round <= nr;
  assign idx      = enc_dec ? nr - rd_round : rd_round;
  assign wr_ready = state == LOAD;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      nr        <= '0;
      mode_q    <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      load_done <= 1'b0;
      rd_key    <= '0;
`ifdef AES_RKEY_ZEROIZE_EN
      z_ptr     <= '0;
      z_load    <= 1'b0;
`endif
    end else begin
      rd_valid  <= rd_ok;
      rd_err    <= (rd_req && !rd_ok) || bad_mode;
      rd_key    <= rd_ok ? mem[idx] : '0;
      load_done <= wr_en && wr_ptr == last;
      if (flush) begin
        wr_ptr <= '0;
        nr     <= '0;
`ifdef AES_RKEY_ZEROIZE_EN
        state  <= ZERO;
        z_ptr  <= '0;
        z_load <= 1'b0;
`else
        state  <= IDLE;
`endif
      end else if (bad_mode) begin
        state  <= IDLE;
        wr_ptr <= '0;
        nr     <= '0;
      end else if (restart) begin
        mode_q <= mode;
        wr_ptr <= '0;
        nr     <= '0;
`ifdef AES_RKEY_ZEROIZE_EN
        state  <= state == IDLE ? LOAD : ZERO;
        z_ptr  <= '0;
        z_load <= 1'b1;
`else
        state  <= LOAD;
`endif
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 4'd1;
        if (wr_ptr == last) begin
          state <= FULL;
          nr    <= last;
        end
      end
`ifdef AES_RKEY_ZEROIZE_EN
      else if (state == ZERO) begin
        z_ptr <= z_ptr + 4'd1;
        if (z_ptr == 4'(DEPTH - 1)) state <= z_load ? LOAD : IDLE;
      end
`endif
    end
  // key storage is deliberately not reset
  always_ff @(posedge clk)
`ifdef AES_RKEY_ZEROIZE_EN
    if (state == ZERO) mem[z_ptr] <= '0;
    else
`endif
    if (wr_en) mem[wr_ptr] <= wr_key;
endmodule

// File: tb/tb_aes_rkey_store.sv
// tb_aes_rkey_store: directed/random checks of aes_rkey_store against a schedule-level model
module tb_aes_rkey_store;
  logic         clk = 0, reset = 0;
  logic [1:0]   mode = 0;
  logic         load_start = 0, flush = 0, wr_valid = 0;
  logic [127:0] wr_key = '0;
  logic         wr_ready;
  logic         rd_req = 0;
  logic [3:0]   rd_round = 0;
  logic         enc_dec = 0;
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         rd_err, load_done;
  logic [3:0]   nr;
  int           vecs = 0, miss = 0;
  logic [127:0] sched [15];
  int           m_nr = 0;
  bit           m_full = 0;

  aes_rkey_store dut (
    .clk(clk), .reset(reset), .mode(mode), .load_start(load_start), .flush(flush),
    .wr_valid(wr_valid), .wr_key(wr_key), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_round(rd_round), .enc_dec(enc_dec),
    .rd_valid(rd_valid), .rd_key(rd_key), .rd_err(rd_err),
    .load_done(load_done), .nr(nr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
    chk({tag, "_rd_key"}, rd_key, 0);
  endtask

  task automatic wait_ready;
`ifdef AES_RKEY_ZEROIZE_EN
    for (int i = 0; i < 40 && !wr_ready; i++) step;
`endif
  endtask

  task automatic start(input logic [1:0] m);
    mode = m;
    load_start = 1;
    step;
    load_start = 0;
    m_full = 0;
    m_nr = 0;
    wait_ready;
    chk("start_ready", wr_ready, 1);
    chk("start_nr", nr, 0);
  endtask

  task automatic feed(input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 200) begin
      guard++;
      wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_key = {$urandom, $urandom, $urandom, $urandom};
      if (wr_valid) sched[i] = wr_key;
      step;
      if (wr_valid) i++;
      chk("load_done", load_done, wr_valid && i == n);
    end
    wr_valid = 0;
    step;
    m_full = 1;
    m_nr = n - 1;
    chk("done_clear", load_done, 0);
    chk("nr", nr, m_nr);
    chk("ready_off", wr_ready, 0);
  endtask

  task automatic rd(input int r, input bit ed);
    bit ok;
    logic [127:0] e;
    rd_req = 1;
    rd_round = r[3:0];
    enc_dec = ed;
    step;
    ok = m_full && r <= m_nr;
    e = ok ? sched[ed ? m_nr - r : r] : '0;
    chk("rd_valid", rd_valid, ok);
    chk("rd_err", rd_err, !ok);
    chk("rd_key", rd_key, e);
  endtask

  task automatic rand_reads(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) != 0) rd($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      else begin
        rd_req = 0;
        step;
        quiet("idle");
      end
    end
    rd_req = 0;
    step;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1;
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_nr", nr, 0);
    quiet("rst");
    @(negedge clk) reset = 0;
    // reserved mode while idle
    mode = 2'b11;
    load_start = 1;
    step;
    load_start = 0;
    chk("res_err", rd_err, 1);
    chk("res_ready", wr_ready, 0);
    chk("res_nr", nr, 0);
    step;
    chk("res_err_clear", rd_err, 0);
    chk("res_ready2", wr_ready, 0);
    // AES-128 schedule, encrypt read of round 3
    start(0);
    feed(11, 0);
    rd(3, 0);
    rd_req = 0;
    step;
    quiet("after_rd");
    // writes outside LOAD are ignored
    wr_valid = 1;
    wr_key = ~sched[0];
    step;
    wr_valid = 0;
    chk("ign_ready", wr_ready, 0);
    rd(0, 0);
    rand_reads(30);
    // AES-256, back-to-back decrypt reads
    start(2);
    feed(15, 0);
    for (int r = 0; r < 15; r++) rd(r, 1);
    rd_req = 0;
    step;
    quiet("b2b_end");
    // AES-192 with stalls, out-of-range round, read during load
    start(1);
    feed(13, 1);
    rd(13, 0);
    rd(12, 1);
    rand_reads(20);
    start(1);
    rd(0, 0);
    rd_req = 0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1;
      wr_key = {$urandom, $urandom, $urandom, $urandom};
      step;
    end
    wr_valid = 0;
    // asynchronous reset mid-load
    #1 reset = 1;
    #1;
    chk("mid_rst_ready", wr_ready, 0);
    chk("mid_rst_nr", nr, 0);
    chk("mid_rst_done", load_done, 0);
    quiet("mid_rst");
    @(negedge clk) reset = 0;
    m_full = 0;
    m_nr = 0;
    rd(0, 0);
    rd_req = 0;
    step;
    start(1);
    feed(13, 0);
    rand_reads(15);
    // same-cycle read and reload: load wins
    rd_req = 1;
    rd_round = 2;
    enc_dec = 0;
    mode = 0;
    load_start = 1;
    step;
    load_start = 0;
    rd_req = 0;
    m_full = 0;
    m_nr = 0;
    chk("pri_err", rd_err, 1);
    chk("pri_valid", rd_valid, 0);
    chk("pri_nr", nr, 0);
`ifndef AES_RKEY_ZEROIZE_EN
    chk("pri_ready", wr_ready, 1);
`endif
    wait_ready;
    feed(11, 0);
    rd(10, 1);
    rd_req = 0;
    // flush overrides everything in its cycle
    flush = 1;
    rd_req = 1;
    wr_valid = 1;
    load_start = 1;
    mode = 0;
    step;
    flush = 0;
    rd_req = 0;
    wr_valid = 0;
    load_start = 0;
    m_full = 0;
    m_nr = 0;
    chk("fl_nr", nr, 0);
    chk("fl_ready", wr_ready, 0);
    chk("fl_valid", rd_valid, 0);
    rd(5, 0);
    rd_req = 0;
    step;
    // reserved mode while FULL drops the schedule
    start(0);
    feed(11, 0);
    mode = 2'b11;
    load_start = 1;
    step;
    load_start = 0;
    m_full = 0;
    m_nr = 0;
    chk("resf_err", rd_err, 1);
    chk("resf_nr", nr, 0);
    chk("resf_ready", wr_ready, 0);
    rd(0, 0);
    rd_req = 0;
    step;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
